// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default payload width and
// parity-type constants. The transmitter and the receiver both import these.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit index for the UART transmitter.
// A load captures a new byte and rewinds the index. A shift moves to the
// next bit, LSB first. data_bit is the bit currently owed to the line.
// next_bit is the bit that becomes current after the next shift.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  data_bit,
    output logic                  next_bit,
    output logic                  last_bit
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    assign data_bit = shreg_q[0];
    assign next_bit = shreg_q[1];
    assign last_bit = (idx_q == IDX_W'(DATA_WIDTH - 1));

    // Next-state logic: a load takes priority over a shift.
    always_comb begin
        // NOTE: every combinational output is defaulted first, so no path can leave one unassigned and infer a latch.
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load) begin
            shreg_d = load_data;
            idx_d   = '0;
        end else if (shift) begin
            shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            idx_d   = last_bit ? '0 : idx_q + IDX_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the payload register is reset as well, so a truncated frame leaves no stale byte behind.
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, an optional
// parity bit and one stop bit. Each line bit lasts `prescale` clocks.
// TX_OUT and Busy are registered. Each is computed from the state being
// entered, so the line changes exactly on bit boundaries.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    uart_state_e               state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] timer_q, timer_d;
    logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
    logic                      par_en_q, par_en_d;
    logic                      par_bit_q, par_bit_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic ser_load, ser_shift;
    logic ser_data_bit, ser_next_bit, ser_last_bit;
    logic timer_wrap;
    logic data_xor;

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    // The latched prescale is never 0, so ps_q - 1 cannot underflow.
    assign timer_wrap = (timer_q == ps_q - PRESCALE_WIDTH'(1));
    assign data_xor   = ^P_DATA;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk       (CLK),
        .rst       (RST),
        .load      (ser_load),
        .shift     (ser_shift),
        .load_data (P_DATA),
        .data_bit  (ser_data_bit),
        .next_bit  (ser_next_bit),
        .last_bit  (ser_last_bit)
    );

    // FSM next state, bit timer, frame-parameter capture and line level.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ps_d      = ps_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;

        // The bit timer runs in every state except IDLE.
        if (state_q != ST_IDLE) begin
            timer_d = timer_wrap ? '0 : timer_q + PRESCALE_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    ser_load  = 1'b1;
                    ps_d      = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
                    par_en_d  = PAR_EN;
                    par_bit_d = (PAR_TYP == PAR_ODD) ? ~data_xor : data_xor;
                    timer_d   = '0;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                if (timer_wrap) begin
                    state_d = ST_DATA;
                    tx_d    = ser_data_bit;
                end
            end
            ST_DATA: begin
                if (timer_wrap) begin
                    ser_shift = 1'b1;
                    if (!ser_last_bit) begin
                        tx_d = ser_next_bit;
                    end else if (par_en_q) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (timer_wrap) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (timer_wrap) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset overrides accept and every transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            ps_q      <= PRESCALE_WIDTH'(1);
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ps_q      <= ps_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Each frame record lists the inputs and
// the hand-computed line sequence (index 0 = first bit on the line).
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [5:0]  ps;
        int          eff_ps;
        int          nbits;
        logic [0:10] line;
    } vec_t;

    uart_tx #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a request and let it be accepted; return just after the accept edge.
    task automatic start_frame(input vec_t v);
        @(negedge CLK);
        P_DATA     = v.data;
        PAR_EN     = v.par_en;
        PAR_TYP    = v.par_typ;
        prescale   = v.ps;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
    endtask

    // Follow the line from just after an accept edge through the first idle cycle.
    // With disturb set, a new request with different settings is driven in bit 2.
    task automatic check_frame(input string tag, input vec_t v, input bit disturb);
        for (int i = 0; i < v.nbits; i++) begin
            logic tx_got;
            logic busy_got;
            tx_got   = v.line[i];
            busy_got = 1'b1;
            for (int c = 0; c < v.eff_ps; c++) begin
                @(negedge CLK);
                if (TX_OUT !== v.line[i]) tx_got = TX_OUT;
                if (Busy !== 1'b1) busy_got = Busy;
                if (disturb && i == 2 && c == 0) begin
                    P_DATA     = 8'h55;
                    PAR_EN     = 1'b1;
                    PAR_TYP    = 1'b1;
                    prescale   = 6'd3;
                    Data_Valid = 1'b1;
                end
            end
            check($sformatf("%s line bit %0d", tag, i), 32'(tx_got), 32'(v.line[i]));
            check($sformatf("%s busy bit %0d", tag, i), 32'(busy_got), 32'd1);
        end
        @(negedge CLK);
        check($sformatf("%s idle tx", tag), 32'(TX_OUT), 32'd1);
        check($sformatf("%s idle busy", tag), 32'(Busy), 32'd0);
    endtask

    vec_t vecs[7];
    vec_t v_dist, v_55, v_07, v_0f;

    initial begin
        vecs[0] = '{8'hAB, 1'b0, 1'b0, 6'd8,  8,  10, 11'b0_11010101_1_1};
        vecs[1] = '{8'hCD, 1'b1, 1'b0, 6'd16, 16, 11, 11'b0_10110011_1_1};
        vecs[2] = '{8'hCD, 1'b1, 1'b1, 6'd16, 16, 11, 11'b0_10110011_0_1};
        vecs[3] = '{8'hEF, 1'b1, 1'b0, 6'd32, 32, 11, 11'b0_11110111_1_1};
        vecs[4] = '{8'hEF, 1'b1, 1'b1, 6'd32, 32, 11, 11'b0_11110111_0_1};
        vecs[5] = '{8'hEF, 1'b0, 1'b1, 6'd32, 32, 10, 11'b0_11110111_1_1};
        vecs[6] = '{8'hA5, 1'b0, 1'b0, 6'd0,  1,  10, 11'b0_10100101_1_1};
        v_dist  = '{8'hAB, 1'b0, 1'b0, 6'd8,  8,  10, 11'b0_11010101_1_1};
        v_55    = '{8'h55, 1'b1, 1'b1, 6'd3,  3,  11, 11'b0_10101010_1_1};
        v_07    = '{8'h07, 1'b0, 1'b0, 6'd4,  4,  10, 11'b0_11100000_1_1};
        v_0f    = '{8'h0F, 1'b0, 1'b0, 6'd4,  4,  10, 11'b0_11110000_1_1};

        // Reset, with a request present to show reset beats accept.
        RST        = 1'b1;
        P_DATA     = 8'h3C;
        Data_Valid = 1'b1;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd4;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset tx", 32'(TX_OUT), 32'd1);
        check("reset busy", 32'(Busy), 32'd0);
        Data_Valid = 1'b0;
        RST        = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle tx", 32'(TX_OUT), 32'd1);
        check("idle busy", 32'(Busy), 32'd0);

        // Table-driven frames.
        for (int k = 0; k < 7; k++) begin
            start_frame(vecs[k]);
            check_frame($sformatf("vec%0d", k), vecs[k], 1'b0);
            repeat (3) @(negedge CLK);
        end

        // Request while busy is ignored; held request goes out after one idle cycle.
        start_frame(v_dist);
        check_frame("busy_ignore", v_dist, 1'b1);
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
        check_frame("held_55", v_55, 1'b0);
        repeat (3) @(negedge CLK);

        // Reset during data bit 3 (line index 4) truncates the frame.
        start_frame(v_07);
        repeat (4 * 4 + 1) @(negedge CLK);
        check("pre-reset bit3 tx", 32'(TX_OUT), 32'd0);
        check("pre-reset busy", 32'(Busy), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("midreset tx", 32'(TX_OUT), 32'd1);
        check("midreset busy", 32'(Busy), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("post-reset tx", 32'(TX_OUT), 32'd1);
        start_frame(v_0f);
        check_frame("after_reset_0f", v_0f, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that converts a parallel byte into an asynchronous frame: start bit, 8 data bits LSB-first, optional parity bit, and one stop bit. It sits directly upstream of the UART receiver and shares its oversampled clock and `prescale` convention, so both ends run from the same CLK. Each line bit is held for exactly `prescale` clock cycles. The block is the loopback driver for receiver verification.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: payload bits per frame.
- `PRESCALE_WIDTH`, default 6: width of the `prescale` input.

Ports:
- `CLK`  in  1: single clock; all logic on the rising edge.
- `RST`  in  1: reset, synchronous and active-high.
- `P_DATA`  in  DATA_WIDTH: byte to transmit, sampled on accept.
- `Data_Valid`  in  1: request to send `P_DATA`. Sampled only in IDLE.
- `PAR_EN`  in  1: 1 inserts a parity bit. Sampled on accept.
- `PAR_TYP`  in  1: 0 selects even parity, 1 selects odd. Sampled on accept.
- `prescale`  in  PRESCALE_WIDTH: clock cycles per line bit. Sampled on accept. A value of 0 is treated as 1.
- `TX_OUT`  out  1: serial line, registered. Idle level is 1.
- `Busy`  out  1: registered. High while a frame is on the line.

## Operation

- States and their line levels:
  - IDLE: `TX_OUT`=1.
  - START: `TX_OUT`=0.
  - DATA: `TX_OUT` = current data bit.
  - PARITY: `TX_OUT` = parity bit.
  - STOP: `TX_OUT`=1.
- Accept: on a rising edge with state IDLE and `Data_Valid`=1:
  - latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `prescale`;
  - go to START.
- Later changes on those inputs do not affect the current frame.
- Data_Valid handling: the block ignores `Data_Valid` in every state except IDLE. There is no queueing and no error flag.
- Bit timer: counts 0..ps-1, where ps is the latched prescale. Each state lasts exactly ps cycles. When the timer wraps, the state advances.
- DATA: 8 bits sent, bit 0 first. A bit index counts 0..7. After bit 7 the next state is PARITY if the latched PAR_EN is 1, otherwise STOP.
- Parity value:
  - even: XOR of the latched byte;
  - odd: inverse of that XOR.
- STOP: lasts ps cycles, then the state returns to IDLE.
- Reset values: state IDLE, `TX_OUT`=1, `Busy`=0, timer=0, bit index=0, latched data=0.
- Reset mid-frame: the same reset values apply on the next edge. The frame is truncated and never resumed. The line returns high immediately.

## Timing

- Accept edge k: at edge k, `TX_OUT`←0 and `Busy`←1. The start bit is therefore visible in the cycle after k (latency 1).
- Frame length: 10·ps cycles without parity, 11·ps with parity. `TX_OUT` changes only on bit boundaries.
- Busy: high for exactly the frame length. It drops on the same edge that ends STOP.
- Back-to-back frames: if `Data_Valid` is held high, the next accept occurs on the first IDLE cycle. The line therefore sees the stop bit plus at least 1 extra idle-high cycle between frames.
- Simultaneous events: `RST` has priority over accept and over every state transition.

## Structure

- Shared package `uart_pkg` holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP);
  - `DATA_WIDTH` default;
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1.
- The receiver imports the same package.
- One sub-module, `uart_tx_serializer`: latched shift register and bit index, with a load/shift interface.
- FSM, bit timer and parity logic stay in the top module.

## Test plan

- Basic frame: ps=8, no parity, P_DATA=0xAB. Expected `TX_OUT`, 8 cycles each: 0,1,1,0,1,0,1,0,1,1. `Busy` high for exactly 80 cycles.
- Parity frames, ps=16, P_DATA=0xCD:
  - PAR_TYP=0: parity bit 1, frame 176 cycles.
  - PAR_TYP=1: parity bit 0.
- Loopback into the receiver, ps=32, 0xEF, each parity mode: receiver `P_DATA`=0xEF and `data_valid` pulses once per frame.
- Inputs ignored while busy:
  - During a frame, assert `Data_Valid` with P_DATA=0x55 and change PAR_EN/prescale → the line stream is unchanged.
  - Holding `Data_Valid` high → 0x55 is sent starting 1 cycle after IDLE is reached.
- Mid-frame reset: assert `RST` during bit 3 → next cycle `TX_OUT`=1 and `Busy`=0. A new 0x0F request then transmits a complete, correct frame.
- prescale=0: frame of 0xA5, no parity → each bit lasts 1 cycle, total 10 cycles.
